lcd_init: RTL and testbench
===========================

LCD_INIT -- requirements
Module: lcd_init

Interface
REQ-001 SHALL use parameter T_POWERUP, default 750000, power-on wait in clk cycles (15 ms at 50 MHz).
REQ-002 SHALL use parameter T_EN, default 20, lcd_en high time in clk cycles.
REQ-003 SHALL use parameter T_CMD, default 2500, post-command wait in clk cycles (50 us).
REQ-004 SHALL use parameter T_FS1, default 205000, wait after first function-set in clk cycles (4.1 ms).
REQ-005 SHALL use parameter T_CLEAR, default 100000, wait after clear command in clk cycles (2 ms).
REQ-006 SHALL have one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port clk, input, 1, system clock, rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port reinit, input, 1, single-cycle request to rerun the sequence.
REQ-010 SHALL have port lcd_rs, output, 1, register select; always 0 in this block.
REQ-011 SHALL have port lcd_rw, output, 1, read/write; always 0.
REQ-012 SHALL have port lcd_en, output, 1, HD44780 enable strobe.
REQ-013 SHALL have port lcd_data, output, 8, command byte.
REQ-014 SHALL have port init_done, output, 1, high while the display is initialised; feeds the downstream display writer.
REQ-015 SHALL have port cmd_idx, output, 3, index of the command being issued.

Function
REQ-016 SHALL implement states POWERUP, SETUP, PULSE, WAIT and DONE.
REQ-017 SHALL stay in POWERUP with lcd_en=0 for T_POWERUP cycles, then go to SETUP with cmd_idx=0.
REQ-018 SHALL issue commands idx 0..7 in order: 0x38, 0x38, 0x38, 0x38, 0x08, 0x01, 0x06, DISP_ON.
REQ-019 SETUP SHALL last 1 cycle, drive lcd_rs=0, lcd_rw=0 and lcd_data=command[cmd_idx], then go to PULSE.
REQ-020 PULSE SHALL hold lcd_en=1 for exactly T_EN cycles, then drive lcd_en=0 and go to WAIT.
REQ-021 lcd_data SHALL stay stable from SETUP through the end of WAIT.
REQ-022 WAIT length SHALL be T_FS1 for idx 0, T_CLEAR for idx 5, and T_CMD for every other idx.
REQ-023 At the end of WAIT: if idx<7, SHALL increment cmd_idx and go to SETUP; if idx=7, SHALL go to DONE.
REQ-024 init_done SHALL rise on the first cycle of DONE and stay high while in DONE; it SHALL be 0 in every other state.
REQ-025 A reinit high in DONE SHALL clear init_done on the next cycle and enter SETUP with idx=0 (no power-up wait).
REQ-026 reinit SHALL be ignored in every state other than DONE.
REQ-027 Delay counters SHALL be wide enough for the largest parameter and SHALL clear on every state change.

Reset
REQ-028 rst high SHALL immediately force state=POWERUP, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, init_done=0, cmd_idx=0 and counters=0.
REQ-029 rst asserted mid-sequence SHALL abort the current command with lcd_en=0 at once.
REQ-030 After rst releases, the block SHALL restart from the full power-up wait.

Configuration
REQ-031 With LCD_INIT_CURSOR_EN defined, DISP_ON SHALL be 0x0F (display, cursor and blink on).
REQ-032 Without LCD_INIT_CURSOR_EN, DISP_ON SHALL be 0x0C (display on, cursor off).

Verification
REQ-033 Parameters 10/2/5/8/6: after rst release, lcd_en rises exactly 10+1 cycles later with lcd_data=0x38.
REQ-034 Full run: exactly 8 lcd_en pulses with data 38,38,38,38,08,01,06,0C; each pulse lasts 2 cycles; init_done rises after the last WAIT.
REQ-035 Gap checks: lcd_en fall to next SETUP is 8 cycles after idx 0, 6 cycles after idx 5, and 5 cycles otherwise.
REQ-036 rst pulsed during the PULSE of idx 3: lcd_en=0 and init_done=0 immediately; after release the sequence restarts at idx 0 after the full power-up wait.
REQ-037 reinit during WAIT is ignored; reinit in DONE drops init_done next cycle and issues 0x38 with no power-up wait.
REQ-038 With LCD_INIT_CURSOR_EN defined: the eighth command is 0x0F.

Source files
------------

// File: rtl/lcd_init_if.sv
// Bus between the HD44780 init sequencer and the display side: the reinit request,
// the LCD pins, init_done/cmd_idx, and a debug view of the sequencer state.
interface lcd_init_if;
  logic       reinit;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;
  logic       init_done;
  logic [2:0] cmd_idx;
  logic [2:0] dbg_state;

  // reinit is a one-cycle request with no ready: it is acted on only while
  // init_done is high, and is silently dropped in every other state.
  modport master (
    input  reinit,
    output lcd_rs, lcd_rw, lcd_en, lcd_data, init_done, cmd_idx, dbg_state
  );

  modport slave (
    output reinit,
    input  lcd_rs, lcd_rw, lcd_en, lcd_data, init_done, cmd_idx, dbg_state
  );
endinterface

// File: rtl/lcd_init.sv
// HD44780 8-bit power-on initialisation sequencer (8 commands, timed enable strobes).
// Define LCD_INIT_CURSOR_EN to turn the cursor and blink on in the final display-on command.
module lcd_init #(
  parameter int T_POWERUP = 750000,
  parameter int T_EN      = 20,
  parameter int T_CMD     = 2500,
  parameter int T_FS1     = 205000,
  parameter int T_CLEAR   = 100000
) (
  input  logic       clk,
  input  logic       rst,
  lcd_init_if.master bus
);

  localparam int M1    = (T_POWERUP > T_EN) ? T_POWERUP : T_EN;
  localparam int M2    = (M1 > T_CMD) ? M1 : T_CMD;
  localparam int M3    = (M2 > T_FS1) ? M2 : T_FS1;
  localparam int T_MAX = (M3 > T_CLEAR) ? M3 : T_CLEAR;
  localparam int CNT_W = $clog2(T_MAX + 1);

`ifdef LCD_INIT_CURSOR_EN
  localparam logic [7:0] DISP_ON = 8'h0F;
`else
  localparam logic [7:0] DISP_ON = 8'h0C;
`endif

  typedef enum logic [2:0] {
    S_POWERUP = 3'd0,
    S_SETUP   = 3'd1,
    S_PULSE   = 3'd2,
    S_WAIT    = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   limit;
  logic               last;
  logic [7:0]         cmd_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_POWERUP;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    cmd_byte = 8'h38;
    case (idx_q)
      3'd4:    cmd_byte = 8'h08;
      3'd5:    cmd_byte = 8'h01;
      3'd6:    cmd_byte = 8'h06;
      3'd7:    cmd_byte = DISP_ON;
      default: cmd_byte = 8'h38;
    endcase
  end

  // The first function-set and the clear need the long settle times.
  always_comb begin
    limit = CNT_W'(1);
    case (state_q)
      S_POWERUP: limit = CNT_W'(T_POWERUP);
      S_PULSE:   limit = CNT_W'(T_EN);
      S_WAIT: begin
        if (idx_q == 3'd0)      limit = CNT_W'(T_FS1);
        else if (idx_q == 3'd5) limit = CNT_W'(T_CLEAR);
        else                    limit = CNT_W'(T_CMD);
      end
      default:   limit = CNT_W'(1);
    endcase
    last = (cnt_q == limit - CNT_W'(1));
  end

  // The counter only runs in timed states and returns to zero on every exit.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = '0;
    case (state_q)
      S_POWERUP: begin
        if (last) begin
          state_d = S_SETUP;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETUP: state_d = S_PULSE;
      S_PULSE: begin
        if (last) state_d = S_WAIT;
        else      cnt_d   = cnt_q + CNT_W'(1);
      end
      S_WAIT: begin
        if (last) begin
          if (idx_q == 3'd7) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETUP;
            idx_d   = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (bus.reinit) begin
          state_d = S_SETUP;
          idx_d   = 3'd0;
        end
      end
      default: state_d = S_POWERUP;
    endcase
  end

  // Outputs decode straight from the state register so reset clears them at once.
  assign bus.lcd_rs    = 1'b0;
  assign bus.lcd_rw    = 1'b0;
  assign bus.lcd_en    = (state_q == S_PULSE);
  assign bus.lcd_data  = (state_q == S_SETUP || state_q == S_PULSE || state_q == S_WAIT)
                         ? cmd_byte : 8'h00;
  assign bus.init_done = (state_q == S_DONE);
  assign bus.cmd_idx   = idx_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_lcd_init.sv
// Bench for lcd_init with short timing parameters (10/2/5/8/6): expected command
// pulses and done events are queued by the stimulus and checked by a negedge monitor.
module tb_lcd_init;

  localparam int W = 20;  // {kind, idx[2:0], data[7:0], gap[7:0]}

  logic clk = 1'b0;
  logic rst = 1'b1;

  lcd_init_if bus();

  lcd_init #(
    .T_POWERUP(10),
    .T_EN     (2),
    .T_CMD    (5),
    .T_FS1    (8),
    .T_CLEAR  (6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

`ifdef LCD_INIT_CURSOR_EN
  localparam logic [7:0] EXP_DISP_ON = 8'h0F;
`else
  localparam logic [7:0] EXP_DISP_ON = 8'h0C;
`endif

  function automatic logic [7:0] exp_cmd(input int i);
    case (i)
      4:       return 8'h08;
      5:       return 8'h01;
      6:       return 8'h06;
      7:       return EXP_DISP_ON;
      default: return 8'h38;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // gap = low-enable negedge samples before the event (0 = not checked).
  task automatic push_seq(input int first_gap);
    int gap;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      gap = first_gap;
      else if (i == 1) gap = 9;   // WAIT 8 + SETUP 1
      else if (i == 6) gap = 7;   // WAIT 6 + SETUP 1
      else             gap = 6;   // WAIT 5 + SETUP 1
      exp_q.push_back({1'b0, 3'(i), exp_cmd(i), 8'(gap)});
    end
    exp_q.push_back({1'b1, 3'd7, 8'h00, 8'd5});
  endtask

  // ---------------- monitor ----------------
  logic       prev_en, prev_done, in_pulse;
  int         hi_cnt, low_cnt;
  logic [7:0] cur_data;
  logic [W-1:0] item;

  always @(negedge clk) begin
    if (rst) begin
      prev_en   = 1'b0;
      prev_done = 1'b0;
      in_pulse  = 1'b0;
      hi_cnt    = 0;
      low_cnt   = 0;
    end else begin
      if (bus.lcd_en && !prev_en) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_pulse: got data 0x%0h idx %0d, expected none", bus.lcd_data, bus.cmd_idx);
        end else begin
          item = exp_q.pop_front();
          check("event_kind_pulse", 32'(bus.init_done), 32'(item[19]));
          check("pulse_idx", 32'(bus.cmd_idx), 32'(item[18:16]));
          check("pulse_data", 32'(bus.lcd_data), 32'(item[15:8]));
          check("pulse_rs_rw", {30'd0, bus.lcd_rs, bus.lcd_rw}, 32'd0);
          if (item[7:0] != 8'd0) check("gap_before_pulse", 32'(low_cnt), 32'(item[7:0]));
        end
        cur_data = bus.lcd_data;
        hi_cnt   = 0;
        in_pulse = 1'b1;
      end
      if (!bus.lcd_en && prev_en && in_pulse) begin
        check("pulse_width", 32'(hi_cnt), 32'd2);
        check("data_stable_after_pulse", 32'(bus.lcd_data), 32'(cur_data));
        in_pulse = 1'b0;
      end
      if (bus.init_done && !prev_done) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got init_done 1, expected 0");
        end else begin
          item = exp_q.pop_front();
          check("event_kind_done", 32'd1, 32'(item[19]));
          check("gap_before_done", 32'(low_cnt), 32'(item[7:0]));
        end
      end
      if (bus.lcd_en) hi_cnt++;
      if (bus.reinit && bus.init_done) low_cnt = 0;
      else if (!bus.lcd_en)            low_cnt++;
      else                             low_cnt = 0;
      prev_en   = bus.lcd_en;
      prev_done = bus.init_done;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got %0d events pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic poll_pulse(input string name, input logic [2:0] idx, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(bus.lcd_en && bus.cmd_idx == idx) && n < budget);
    if (!(bus.lcd_en && bus.cmd_idx == idx)) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got no pulse, expected pulse for idx %0d", name, idx);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},    32'(bus.lcd_en), 32'd0);
    check({tag, "_done"},  32'(bus.init_done), 32'd0);
    check({tag, "_idx"},   32'(bus.cmd_idx), 32'd0);
    check({tag, "_data"},  32'(bus.lcd_data), 32'h00);
    check({tag, "_rsrw"},  {30'd0, bus.lcd_rs, bus.lcd_rw}, 32'd0);
    check({tag, "_state"}, 32'(bus.dbg_state), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.reinit = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Full sequence; reinit during POWERUP and during WAIT of idx 2 must be ignored.
    push_seq(11);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.reinit = 1'b1;
    @(posedge clk); #1 bus.reinit = 1'b0;
    poll_pulse("idx2", 3'd2, 200);
    while (bus.lcd_en) begin
      @(posedge clk); #1;
    end
    bus.reinit = 1'b1;
    @(posedge clk); #1 bus.reinit = 1'b0;
    wait_empty("first_run", 300);
    check("done_high", 32'(bus.init_done), 32'd1);
    check("done_state", 32'(bus.dbg_state), 32'd4);
    check("done_data", 32'(bus.lcd_data), 32'h00);
    repeat (4) @(posedge clk);
    #1 check("done_holds", 32'(bus.init_done), 32'd1);

    // reinit in DONE: no power-up wait, SETUP on the next cycle.
    push_seq(1);
    bus.reinit = 1'b1;
    @(posedge clk); #1;
    bus.reinit = 1'b0;
    check("reinit_done_drop", 32'(bus.init_done), 32'd0);
    check("reinit_idx", 32'(bus.cmd_idx), 32'd0);
    check("reinit_setup_data", 32'(bus.lcd_data), 32'h38);
    check("reinit_state", 32'(bus.dbg_state), 32'd1);
    wait_empty("reinit_run", 300);
    check("reinit_done_high", 32'(bus.init_done), 32'd1);

    // Reset in the middle of the idx 3 enable pulse.
    push_seq(1);
    bus.reinit = 1'b1;
    @(posedge clk); #1 bus.reinit = 1'b0;
    poll_pulse("idx3", 3'd3, 200);
    #2 rst = 1'b1;
    exp_q.delete();
    #1 check_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    push_seq(11);
    #1 rst = 1'b0;
    wait_empty("after_reset", 300);
    check("final_done_high", 32'(bus.init_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
